// File: rtl/mmio_port_responder.sv
// MMIO responder for the MEM-stage load/store path: PortOut register, synchronised PortIn
// with change tracking. Define PORT_IRQ_EN to add the IRQ_EN register and the Irq output.
module mmio_port_responder #(
    parameter int unsigned      NBits       = 32,
    parameter int unsigned      IN_WIDTH    = 8,
    parameter int unsigned      SYNC_STAGES = 2,
    parameter logic [NBits-1:0] BASE_ADDR   = NBits'(32'h1001_0040)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                MemRead,
    input  logic                MemWrite,
    input  logic [NBits-1:0]    Address,
    input  logic [NBits-1:0]    WriteData,
    input  logic [IN_WIDTH-1:0] PortIn,
    output logic [NBits-1:0]    ReadData,
    output logic                Hit,
    output logic [NBits-1:0]    PortOut
`ifdef PORT_IRQ_EN
    ,
    output logic                Irq
`endif
);

    localparam int unsigned CNT_W        = 8;
    localparam logic [2:0]  IDX_PORT_OUT = 3'd0;
    localparam logic [2:0]  IDX_PORT_IN  = 3'd1;
    localparam logic [2:0]  IDX_STATUS   = 3'd2;
    localparam logic [2:0]  IDX_CHG_CNT  = 3'd3;
    localparam logic [2:0]  IDX_IRQ_EN   = 3'd4;

    logic [NBits-1:0]                       port_out_q, port_out_d;
    logic [SYNC_STAGES-1:0][IN_WIDTH-1:0]   sync_q, sync_d;
    logic [IN_WIDTH-1:0]                    prev_q, prev_d;
    logic                                   changed_q, changed_d;
    logic                                   overrun_q, overrun_d;
    logic [CNT_W-1:0]                       chg_count_q, chg_count_d;
`ifdef PORT_IRQ_EN
    logic [1:0]                             irq_en_q, irq_en_d;
    logic                                   irq_q, irq_d;
`endif

    logic [NBits-1:0]    offset_c;
    logic [2:0]          idx_c;
    logic                hit_c;
    logic                wr_en_c;
    logic                change_c;
    logic [IN_WIDTH-1:0] port_in_c;
    logic [NBits-1:0]    rd_data_c;

    // Address decode: unsigned offset catches both below-base and above-window addresses
    always_comb begin
        offset_c  = Address - BASE_ADDR;
        idx_c     = offset_c[4:2];
        hit_c     = (MemRead | MemWrite) && (offset_c[NBits-1:5] == '0) && (offset_c[1:0] == 2'b00);
        wr_en_c   = MemWrite & hit_c;
        port_in_c = sync_q[SYNC_STAGES-1];
        change_c  = (port_in_c != prev_q);
    end

    // Read mux returns the pre-write register values
    always_comb begin
        rd_data_c = '0;
        if (MemRead && hit_c) begin
            case (idx_c)
                IDX_PORT_OUT: rd_data_c = port_out_q;
                IDX_PORT_IN:  rd_data_c = NBits'(port_in_c);
                IDX_STATUS:   rd_data_c = NBits'({overrun_q, changed_q});
                IDX_CHG_CNT:  rd_data_c = NBits'(chg_count_q);
`ifdef PORT_IRQ_EN
                IDX_IRQ_EN:   rd_data_c = NBits'(irq_en_q);
`endif
                default:      rd_data_c = '0;
            endcase
        end
    end

    // Next-state: clears from the bus first, then change events override them
    always_comb begin
        port_out_d  = port_out_q;
        sync_d      = {sync_q[SYNC_STAGES-2:0], PortIn};
        prev_d      = port_in_c;
        changed_d   = changed_q;
        overrun_d   = overrun_q;
        chg_count_d = chg_count_q;
`ifdef PORT_IRQ_EN
        irq_en_d    = irq_en_q;
        irq_d       = (changed_q & irq_en_q[0]) | (overrun_q & irq_en_q[1]);
`endif

        if (wr_en_c) begin
            case (idx_c)
                IDX_PORT_OUT: port_out_d = WriteData;
                IDX_STATUS: begin
                    if (WriteData[0]) changed_d = 1'b0;
                    if (WriteData[1]) overrun_d = 1'b0;
                end
                IDX_CHG_CNT:  chg_count_d = '0;
`ifdef PORT_IRQ_EN
                IDX_IRQ_EN:   irq_en_d = WriteData[1:0];
`endif
                default: ;
            endcase
        end

        if (change_c) begin
            changed_d = 1'b1;
            if (changed_q) overrun_d = 1'b1;
            if (chg_count_d != {CNT_W{1'b1}}) chg_count_d = chg_count_d + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            port_out_q  <= '0;
            sync_q      <= '0;
            prev_q      <= '0;
            changed_q   <= 1'b0;
            overrun_q   <= 1'b0;
            chg_count_q <= '0;
`ifdef PORT_IRQ_EN
            irq_en_q    <= '0;
            irq_q       <= 1'b0;
`endif
        end else begin
            port_out_q  <= port_out_d;
            sync_q      <= sync_d;
            prev_q      <= prev_d;
            changed_q   <= changed_d;
            overrun_q   <= overrun_d;
            chg_count_q <= chg_count_d;
`ifdef PORT_IRQ_EN
            irq_en_q    <= irq_en_d;
            irq_q       <= irq_d;
`endif
        end
    end

    assign ReadData = rd_data_c;
    assign Hit      = hit_c;
    assign PortOut  = port_out_q;
`ifdef PORT_IRQ_EN
    assign Irq      = irq_q;
`endif

endmodule

// File: tb/tb_mmio_port_responder.sv
// Directed self-checking bench for mmio_port_responder (default build; Irq checks under PORT_IRQ_EN).
module tb_mmio_port_responder;

    localparam logic [31:0] BASE = 32'h1001_0040;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemRead, MemWrite;
    logic [31:0] Address, WriteData;
    logic [7:0]  PortIn;
    logic [31:0] ReadData;
    logic        Hit;
    logic [31:0] PortOut;
`ifdef PORT_IRQ_EN
    logic        Irq;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    mmio_port_responder dut (
        .clk       (clk),
        .reset     (reset),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .Address   (Address),
        .WriteData (WriteData),
        .PortIn    (PortIn),
        .ReadData  (ReadData),
        .Hit       (Hit),
        .PortOut   (PortOut)
`ifdef PORT_IRQ_EN
        ,
        .Irq       (Irq)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data);
        MemWrite  = 1'b1;
        Address   = addr;
        WriteData = data;
        tick();
        MemWrite  = 1'b0;
        Address   = '0;
    endtask

    task automatic do_read(input logic [31:0] addr, output logic [31:0] data, output logic hit);
        MemRead = 1'b1;
        Address = addr;
        #1;
        data    = ReadData;
        hit     = Hit;
        MemRead = 1'b0;
        Address = '0;
        #1;
    endtask

    task automatic read_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        logic        h;
        do_read(addr, d, h);
        check_eq(tag, d, exp);
    endtask

    initial begin
        logic [31:0] d;
        logic        h;

        reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0;
        Address = '0; WriteData = '0; PortIn = 8'h00;
        #1;
        check_eq("rst_portout", PortOut, 32'h0);
        check_eq("rst_hit", {31'b0, Hit}, 32'h0);
        tick(2);
        reset = 1'b0;
        read_check("rst_status", BASE + 32'h08, 32'h0);
        read_check("rst_count", BASE + 32'h0C, 32'h0);

        // PORT_OUT write and read-back
        MemWrite = 1'b1; Address = BASE; WriteData = 32'hDEAD_BEEF;
        #1;
        check_eq("wr_hit", {31'b0, Hit}, 32'h1);
        check_eq("wr_before_edge", PortOut, 32'h0);
        tick();
        MemWrite = 1'b0;
        check_eq("wr_portout", PortOut, 32'hDEAD_BEEF);
        do_read(BASE, d, h);
        check_eq("rd_portout", d, 32'hDEAD_BEEF);
        check_eq("rd_hit", {31'b0, h}, 32'h1);

        // Synchroniser latency and change detection
        PortIn = 8'h5A;
        tick();
        read_check("sync_1edge", BASE + 32'h04, 32'h0);
        tick();
        read_check("sync_2edge", BASE + 32'h04, 32'h5A);
        read_check("status_2edge", BASE + 32'h08, 32'h0);
        tick();
        read_check("status_3edge", BASE + 32'h08, 32'h1);
        read_check("count_3edge", BASE + 32'h0C, 32'h1);

        // Overrun, W1C, set-wins-over-clear
        PortIn = 8'hA5;
        tick(3);
        read_check("status_overrun", BASE + 32'h08, 32'h3);
        read_check("count_2", BASE + 32'h0C, 32'h2);
        do_write(BASE + 32'h08, 32'h1);
        read_check("status_w1c", BASE + 32'h08, 32'h2);
        PortIn = 8'h3C;
        tick(2);
        do_write(BASE + 32'h08, 32'h1);
        read_check("status_set_wins", BASE + 32'h08, 32'h3);
        do_write(BASE + 32'h08, 32'h3);
        read_check("status_clr_all", BASE + 32'h08, 32'h0);

        // Saturation and clear-with-change
        for (int i = 0; i < 300; i++) begin
            PortIn = ~PortIn;
            tick();
        end
        tick(3);
        read_check("count_sat", BASE + 32'h0C, 32'hFF);
        PortIn = 8'h77;
        tick(2);
        do_write(BASE + 32'h0C, 32'h0);
        read_check("count_clr_change", BASE + 32'h0C, 32'h1);
        do_write(BASE + 32'h0C, 32'hFFFF_FFFF);
        read_check("count_clr", BASE + 32'h0C, 32'h0);

        // Misses: misaligned, past window, below base
        MemWrite = 1'b1; Address = BASE + 32'h02; WriteData = 32'h1111_1111;
        #1;
        check_eq("miss_misalign_hit", {31'b0, Hit}, 32'h0);
        tick();
        Address = BASE + 32'h20;
        #1;
        check_eq("miss_window_hit", {31'b0, Hit}, 32'h0);
        tick();
        Address = BASE - 32'h04;
        tick();
        MemWrite = 1'b0;
        check_eq("miss_portout", PortOut, 32'hDEAD_BEEF);
        read_check("miss_rd_misalign", BASE + 32'h02, 32'h0);
        read_check("miss_rd_window", BASE + 32'h20, 32'h0);
        do_read(BASE + 32'h14, d, h);
        check_eq("unmapped_rd", d, 32'h0);
        check_eq("unmapped_hit", {31'b0, h}, 32'h1);
`ifndef PORT_IRQ_EN
        do_write(BASE + 32'h10, 32'h3);
        read_check("irq_en_absent", BASE + 32'h10, 32'h0);
`endif

        // Read and write together: read sees old value
        MemRead = 1'b1; MemWrite = 1'b1; Address = BASE; WriteData = 32'h1234_5678;
        #1;
        check_eq("rw_old_data", ReadData, 32'hDEAD_BEEF);
        tick();
        MemRead = 1'b0; MemWrite = 1'b0;
        check_eq("rw_new_portout", PortOut, 32'h1234_5678);

        // Reset mid-store, then nonzero PortIn seen as a change at release
        MemWrite = 1'b1; Address = BASE; WriteData = 32'hCAFE_F00D;
        PortIn = 8'h81;
        #2;
        reset = 1'b1;
        #1;
        check_eq("rst_mid_portout", PortOut, 32'h0);
        MemWrite = 1'b0;
        tick();
        reset = 1'b0;
        read_check("rst_mid_count", BASE + 32'h0C, 32'h0);
        tick(2);
        read_check("rel_status_2", BASE + 32'h08, 32'h0);
        tick();
        read_check("rel_status_3", BASE + 32'h08, 32'h1);
        do_write(BASE + 32'h08, 32'h3);

`ifdef PORT_IRQ_EN
        do_write(BASE + 32'h10, 32'hFFFF_FFFF);
        read_check("irq_en_mask", BASE + 32'h10, 32'h3);
        do_write(BASE + 32'h10, 32'h1);
        read_check("irq_en_rd", BASE + 32'h10, 32'h1);
        PortIn = 8'h18;
        tick(3);
        check_eq("irq_edge3", {31'b0, Irq}, 32'h0);
        tick();
        check_eq("irq_edge4", {31'b0, Irq}, 32'h1);
        do_write(BASE + 32'h08, 32'h1);
        check_eq("irq_clr_edge", {31'b0, Irq}, 32'h1);
        tick();
        check_eq("irq_deassert", {31'b0, Irq}, 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
